// File: rtl/adder_stim_gen_pkg.sv
// Shared types and constants for the adder operand stimulus generator.
// Pattern modes, FSM states, LFSR mask, default seeds and the corner table.
package adder_stim_pkg;

    typedef enum logic [1:0] {
        MODE_RAND   = 2'd0,
        MODE_CORNER = 2'd1,
        MODE_SWEEP  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    localparam logic [31:0] LFSR_MASK  = 32'hA300_0000;
    localparam logic [31:0] DEF_SEED_A = 32'h0000_0001;
    localparam logic [31:0] DEF_SEED_B = 32'hACE1_2468;

    localparam pair_t CORNER_TBL [8] = '{
        '{32'h0000_0000, 32'h0000_0000},
        '{32'hFFFF_FFFF, 32'h0000_0001},
        '{32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{32'h8000_0000, 32'h8000_0000},
        '{32'h7FFF_FFFF, 32'h0000_0001},
        '{32'hAAAA_AAAA, 32'h5555_5555},
        '{32'h5555_5555, 32'h5555_5555},
        '{32'hFFFF_0000, 32'h0001_0000}
    };

    // Encoding 3 is not a pattern of its own; it falls back to random.
    function automatic mode_e decode_mode(input logic [1:0] m);
        mode_e r;
        unique case (m)
            2'd1:    r = MODE_CORNER;
            2'd2:    r = MODE_SWEEP;
            default: r = MODE_RAND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/adder_stim_gen_if.sv
// Operand-pair stream: one (dataa, datab) pair per valid&ready transfer.
// The generator drives the master side, the adder harness the slave side.
interface adder_stim_gen_if;

    logic [31:0] dataa;
    logic [31:0] datab;
    logic        valid;
    logic        ready;
    logic        last;

    modport master (
        output dataa,
        output datab,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  dataa,
        input  datab,
        input  valid,
        input  last,
        output ready
    );

endinterface

// File: rtl/adder_stim_gen_lfsr32.sv
// 32-bit right-shifting Galois LFSR with seed reload.
// Reset and load both restore the seed so each run is reproducible.
module lfsr32
    import adder_stim_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        adv,
    output logic [31:0] q
);

    logic [31:0] q_next;

    always_comb begin
        q_next = {1'b0, q[31:1]};
        if (q[0]) q_next = q_next ^ LFSR_MASK;
    end

    always_ff @(posedge Clk) begin
        if (Rst || load) q <= seed;
        else if (adv)    q <= q_next;
    end

endmodule

// File: rtl/adder_stim_gen.sv
// Operand-pair source for approximate-adder characterisation.
// Emits num_pairs pairs in random, corner or sweep pattern, then pulses done.
module adder_stim_gen
    import adder_stim_pkg::*;
#(
    parameter logic [31:0] SEED_A = DEF_SEED_A,
    parameter logic [31:0] SEED_B = DEF_SEED_B
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [31:0]       num_pairs,
    adder_stim_gen_if.master  bus,
    output logic              busy,
    output logic              done
);

    state_e      state_q;
    state_e      state_d;
    mode_e       mode_q;
    logic [31:0] np_q;
    logic [31:0] cnt_q;
    logic [31:0] lfsr_a;
    logic [31:0] lfsr_b;
    logic        xfer;
    logic        at_end;
    logic        start_idle;
    logic        start_run;
    logic        run_q;
    pair_t       pair;

    assign run_q      = (state_q == S_RUN);
    assign xfer       = run_q & bus.ready;
    assign at_end     = (cnt_q == np_q - 32'd1);
    assign start_idle = (state_q == S_IDLE) & start;
    assign start_run  = start_idle & (num_pairs != 32'd0);

    always_ff @(posedge Clk) begin
        if (Rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = (num_pairs != 32'd0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                if (xfer && at_end) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q  <= '0;
            np_q   <= '0;
            mode_q <= MODE_RAND;
        end else if (start_run) begin
            cnt_q  <= '0;
            np_q   <= num_pairs;
            mode_q <= decode_mode(mode);
        end else if (xfer) begin
            cnt_q  <= cnt_q + 32'd1;
        end
    end

    lfsr32 u_lfsr_a (
        .Clk  (Clk),
        .Rst  (Rst),
        .load (start_idle),
        .seed (SEED_A),
        .adv  (xfer),
        .q    (lfsr_a)
    );

    lfsr32 u_lfsr_b (
        .Clk  (Clk),
        .Rst  (Rst),
        .load (start_idle),
        .seed (SEED_B),
        .adv  (xfer),
        .q    (lfsr_b)
    );

    always_comb begin
        unique case (1'b1)
            (mode_q == MODE_CORNER): pair = CORNER_TBL[cnt_q[2:0]];
            (mode_q == MODE_SWEEP):  pair = '{cnt_q, ~cnt_q};
            default:                 pair = '{lfsr_a, lfsr_b};
        endcase
    end

    // Pair is a function of held state only, so it is stable across stalls.
    always_comb begin
        bus.valid = run_q;
        bus.last  = run_q & at_end;
        bus.dataa = run_q ? pair.a : 32'd0;
        bus.datab = run_q ? pair.b : 32'd0;
        busy      = run_q;
        done      = (state_q == S_DONE);
    end

endmodule
